// File: rtl/cnt_pkg.sv
// Shared definitions for the mod-M up/down accumulators: FSM state encoding
// and the single-step modular reduction helper.
package cnt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SAT  = 2'd2
    } cnt_state_e;

    // One conditional subtraction only: valid for x < 2*m.
    function automatic logic [31:0] red_mod(input logic [31:0] x, input logic [31:0] m);
        return (x >= m) ? (x - m) : x;
    endfunction

endpackage

// File: rtl/mod_sub.sv
// Combinational modular subtractor: diff = (a - b) mod M for a, b in [0, M-1],
// with borrow flagging that the raw difference went below zero.
module mod_sub #(
    parameter int M = 100,
    parameter int W = $clog2(M)
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         borrow
);

    localparam logic [W-1:0] M_W = W'(M);

    logic [W:0]   raw;
    logic [W-1:0] wrapped;

    // Adding M modulo 2^W is exact because the true result lies in [0, M-1].
    assign raw     = {1'b0, a} - {1'b0, b};
    assign borrow  = raw[W];
    assign wrapped = raw[W-1:0] + M_W;
    assign diff    = borrow ? wrapped : raw[W-1:0];

endmodule

// File: rtl/decum_mod.sv
// Modular down-accumulator acc <= (acc - data) mod M with valid/ready input,
// per-step borrow flag and a saturating wrap counter that stalls input when full.
module decum_mod
    import cnt_pkg::*;
#(
    parameter  int M      = 100,
    parameter  int WRAP_W = 8,
    localparam int W      = $clog2(M)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              load,
    input  logic [W-1:0]      load_val,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W-1:0]      data,
    output logic              out_valid,
    output logic [W-1:0]      acc,
    output logic              borrow,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic              sat
);

    localparam logic [1:0]        ST_IDLE  = IDLE;
    localparam logic [1:0]        ST_RUN   = RUN;
    localparam logic [1:0]        ST_SAT   = SAT;
    localparam logic [WRAP_W-1:0] WRAP_MAX = '1;

    logic [1:0]        state;
    logic [W-1:0]      data_red;
    logic [W-1:0]      load_red;
    logic [W-1:0]      sub_diff;
    logic              sub_borrow;
    logic [WRAP_W-1:0] wrap_next;
    logic              fire;

    assign data_red = W'(red_mod(32'(data), 32'(M)));
    assign load_red = W'(red_mod(32'(load_val), 32'(M)));

    mod_sub #(.M(M), .W(W)) u_sub (
        .a      (acc),
        .b      (data_red),
        .diff   (sub_diff),
        .borrow (sub_borrow)
    );

    // clr and load own the edge, so refuse data rather than drop it.
    assign in_ready  = !clr && !load && (state != ST_SAT);
    assign fire      = in_valid && in_ready;
    assign wrap_next = (sub_borrow && (wrap_cnt != WRAP_MAX)) ? wrap_cnt + 1'b1 : wrap_cnt;
    assign sat       = (wrap_cnt == WRAP_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            acc       <= '0;
            borrow    <= 1'b0;
            wrap_cnt  <= '0;
            out_valid <= 1'b0;
        end else if (clr) begin
            state     <= ST_IDLE;
            acc       <= '0;
            borrow    <= 1'b0;
            wrap_cnt  <= '0;
            out_valid <= 1'b0;
        end else if (load) begin
            acc       <= load_red;
            borrow    <= 1'b0;
            out_valid <= 1'b0;
        end else if (fire) begin
            acc       <= sub_diff;
            borrow    <= sub_borrow;
            out_valid <= 1'b1;
            wrap_cnt  <= wrap_next;
            // SAT is entered on the same edge the counter reaches its maximum.
            state     <= (wrap_next == WRAP_MAX) ? ST_SAT : ST_RUN;
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decum_mod.sv
// Directed vector table plus reset and random sequences for decum_mod (M=100, WRAP_W=2).
module tb_decum_mod;

    localparam int M      = 100;
    localparam int W      = 7;
    localparam int WRAP_W = 2;
    localparam int NVEC   = 17;

    logic              clk;
    logic              rst_n;
    logic              clr;
    logic              load;
    logic [W-1:0]      load_val;
    logic              in_valid;
    logic              in_ready;
    logic [W-1:0]      data;
    logic              out_valid;
    logic [W-1:0]      acc;
    logic              borrow;
    logic [WRAP_W-1:0] wrap_cnt;
    logic              sat;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int clr;
        int load;
        int load_val;
        int in_valid;
        int data;
        int exp_ready;
        int exp_acc;
        int exp_borrow;
        int exp_wrap;
        int exp_ov;
        int exp_sat;
    } vec_t;

    vec_t vecs[NVEC];

    int m_acc, m_b, m_wrap, m_ov, m_st, m_ready, dr;

    decum_mod #(.M(M), .WRAP_W(WRAP_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .load      (load),
        .load_val  (load_val),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data      (data),
        .out_valid (out_valid),
        .acc       (acc),
        .borrow    (borrow),
        .wrap_cnt  (wrap_cnt),
        .sat       (sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1)
            check_output("acc_lt_m", {31'd0, (acc < W'(M))}, 32'd1);
    end

    task automatic drive(input int c, input int l, input int lv, input int iv, input int d);
        clr      = c[0];
        load     = l[0];
        load_val = W'(lv);
        in_valid = iv[0];
        data     = W'(d);
    endtask

    task automatic check_all(input string tag, input int e_acc, input int e_b, input int e_w,
                             input int e_ov, input int e_sat);
        check_output({tag, ".acc"},       32'(acc),       e_acc);
        check_output({tag, ".borrow"},    32'(borrow),    e_b);
        check_output({tag, ".wrap_cnt"},  32'(wrap_cnt),  e_w);
        check_output({tag, ".out_valid"}, 32'(out_valid), e_ov);
        check_output({tag, ".sat"},       32'(sat),       e_sat);
    endtask

    task automatic apply_stimulus(input int idx);
        vec_t v;
        v = vecs[idx];
        drive(v.clr, v.load, v.load_val, v.in_valid, v.data);
        #1;
        check_output($sformatf("v%0d.in_ready", idx), 32'(in_ready), v.exp_ready);
        @(posedge clk);
        #1;
        check_all($sformatf("v%0d", idx), v.exp_acc, v.exp_borrow, v.exp_wrap, v.exp_ov, v.exp_sat);
    endtask

    initial begin
        //           clr load lv  iv data rdy acc  b  w  ov sat
        vecs[0]  = '{0, 0,   0,  1, 30,  1,  70, 1, 1, 1, 0};
        vecs[1]  = '{0, 1,   50, 1, 5,   0,  50, 0, 1, 0, 0};
        vecs[2]  = '{0, 0,   0,  1, 20,  1,  30, 0, 1, 1, 0};
        vecs[3]  = '{0, 0,   0,  1, 20,  1,  10, 0, 1, 1, 0};
        vecs[4]  = '{0, 0,   0,  1, 10,  1,  0,  0, 1, 1, 0};
        vecs[5]  = '{0, 0,   0,  0, 0,   1,  0,  0, 1, 0, 0};
        vecs[6]  = '{0, 0,   0,  1, 127, 1,  73, 1, 2, 1, 0};
        vecs[7]  = '{0, 0,   0,  1, 0,   1,  73, 0, 2, 1, 0};
        vecs[8]  = '{0, 0,   0,  1, 73,  1,  0,  0, 2, 1, 0};
        vecs[9]  = '{0, 0,   0,  1, 1,   1,  99, 1, 3, 1, 1};
        vecs[10] = '{0, 0,   0,  1, 5,   0,  99, 1, 3, 0, 1};
        vecs[11] = '{1, 0,   0,  0, 0,   0,  0,  0, 0, 0, 0};
        vecs[12] = '{0, 0,   0,  0, 0,   1,  0,  0, 0, 0, 0};
        vecs[13] = '{1, 1,   40, 1, 10,  0,  0,  0, 0, 0, 0};
        vecs[14] = '{0, 1,   40, 1, 10,  0,  40, 0, 0, 0, 0};
        vecs[15] = '{0, 1,   120,0, 0,   0,  20, 0, 0, 0, 0};
        vecs[16] = '{0, 0,   0,  1, 20,  1,  0,  0, 0, 1, 0};

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 0, 0, 0, 0, 0);
        check_output("reset.in_ready", 32'(in_ready), 1);
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++)
            apply_stimulus(i);

        // Asynchronous reset mid-operation, no clock edge involved.
        drive(0, 1, 77, 0, 0);
        @(posedge clk);
        #1;
        drive(0, 0, 0, 1, 90);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async_rst", 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        m_acc = 0; m_b = 0; m_wrap = 0; m_ov = 0; m_st = 0;
        for (int i = 0; i < 10000; i++) begin
            int c, l, lv, iv, d;
            c  = ($urandom_range(0, 63) == 0) ? 1 : 0;
            l  = ($urandom_range(0, 15) == 0) ? 1 : 0;
            lv = $urandom_range(0, 127);
            iv = ($urandom_range(0, 3) != 0) ? 1 : 0;
            d  = $urandom_range(0, 127);
            drive(c, l, lv, iv, d);
            if (i == 5000) begin
                #2;
                rst_n = 1'b0;
                #1;
                check_all("rand_rst", 0, 0, 0, 0, 0);
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                m_acc = 0; m_b = 0; m_wrap = 0; m_ov = 0; m_st = 0;
                continue;
            end
            m_ready = (c == 0 && l == 0 && m_st != 2) ? 1 : 0;
            #1;
            check_output("rand.in_ready", 32'(in_ready), m_ready);
            @(posedge clk);
            #1;
            if (c != 0) begin
                m_acc = 0; m_b = 0; m_wrap = 0; m_ov = 0; m_st = 0;
            end else if (l != 0) begin
                m_acc = (lv >= M) ? lv - M : lv;
                m_b = 0; m_ov = 0;
            end else if (iv != 0 && m_ready != 0) begin
                dr = (d >= M) ? d - M : d;
                if (dr > m_acc) begin
                    m_acc = m_acc + M - dr;
                    m_b = 1;
                    if (m_wrap < 3) m_wrap++;
                end else begin
                    m_acc = m_acc - dr;
                    m_b = 0;
                end
                m_ov = 1;
                m_st = (m_wrap == 3) ? 2 : 1;
            end else begin
                m_ov = 0;
            end
            check_all("rand", m_acc, m_b, m_wrap, m_ov, (m_wrap == 3) ? 1 : 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
